mem_port_arbiter: RTL and testbench

- Shares one single-port, synchronous, word-addressed 32-bit memory between three requesters: instruction fetch (IF), CPU load/store (LS), and a debug/loader port (DBG).
- Sits between the RV32I core's fetch/memory stages and a unified instruction/data RAM, replacing the separate imem/dmem arrays.
- Fixed priority DBG > LS > IF, with an anti-starvation boost for IF. The memory has 1-cycle read latency.
- Supports a new grant every cycle, with responses routed back by a registered owner tag.

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_port_arbiter_starve_ctr.sv | 38 +++
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 tb/tb_mem_port_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared constants for the unified memory port arbiter
package mem_port_arbiter_pkg;

  typedef logic [1:0] owner_t;

  localparam owner_t OWN_NONE = 2'd0;
  localparam owner_t OWN_IF   = 2'd1;
  localparam owner_t OWN_LS   = 2'd2;
  localparam owner_t OWN_DBG  = 2'd3;

  localparam int         DATA_W  = 32;
  localparam logic [3:0] BE_FULL = 4'hF;
  localparam int         CNT_W   = 4;

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// rtl/mem_port_arbiter_starve_ctr.sv - IF starvation counter and priority boost flag
module starve_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic if_gnt,
  output logic boost
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             denied;

  assign denied  = if_req && !if_gnt;
  assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

  // boost is raised on the same edge the count reaches the limit, so IF wins the very next cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      boost <= 1'b0;
    end else begin
      cnt <= denied ? cnt_inc : '0;
      if (if_gnt) begin
        boost <= 1'b0;
      end else if (denied && cnt_inc == LIMIT) begin
        boost <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - three-way arbiter (DBG > LS > IF, IF boost) onto one synchronous RAM port
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [3:0]        ls_be,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_stall
);

  logic   boost;
  owner_t owner_q;
  owner_t owner_d;

  starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve_ctr (
    .clk    (clk),
    .reset  (reset),
    .if_req (if_req),
    .if_gnt (if_gnt),
    .boost  (boost)
  );

  // grants are held low while reset is asserted so nothing reaches the RAM
  always_comb begin
    if_gnt  = 1'b0;
    ls_gnt  = 1'b0;
    dbg_gnt = 1'b0;
    if (reset) begin
      if (dbg_req) begin
        dbg_gnt = 1'b1;
      end else if (boost && if_req) begin
        if_gnt = 1'b1;
      end else if (ls_req) begin
        ls_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_we    = 4'h0;
    mem_addr  = '0;
    mem_wdata = '0;
    owner_d   = OWN_NONE;
    if (dbg_gnt) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_we    = dbg_we ? BE_FULL : 4'h0;
      owner_d   = dbg_we ? OWN_NONE : OWN_DBG;
    end else if (ls_gnt) begin
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
      mem_we    = ls_we ? ls_be : 4'h0;
      owner_d   = ls_we ? OWN_NONE : OWN_LS;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
      owner_d   = OWN_IF;
    end
  end

  assign mem_en    = if_gnt || ls_gnt || dbg_gnt;
  assign cpu_stall = reset && ((if_req && !if_gnt) || (ls_req && !ls_gnt));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign if_rvalid  = (owner_q == OWN_IF);
  assign ls_rvalid  = (owner_q == OWN_LS);
  assign dbg_rvalid = (owner_q == OWN_DBG);

  assign if_rdata  = if_rvalid  ? mem_rdata : '0;
  assign ls_rdata  = ls_rvalid  ? mem_rdata : '0;
  assign dbg_rdata = dbg_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench with a per-cycle arbitration/memory reference model
module tb_mem_port_arbiter;

  localparam int AW = 8;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, ls_req, ls_we, dbg_req, dbg_we;
  logic [AW-1:0] if_addr, ls_addr, dbg_addr;
  logic [3:0]    ls_be;
  logic [31:0]   ls_wdata, dbg_wdata;
  logic          if_gnt, ls_gnt, dbg_gnt, if_rvalid, ls_rvalid, dbg_rvalid;
  logic [31:0]   if_rdata, ls_rdata, dbg_rdata;
  logic          mem_en, cpu_stall;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(.ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_stall(cpu_stall)
  );

  always #5 clk = ~clk;

  // RAM the arbiter drives: synchronous, one port, byte-writable
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      if (mem_we == 4'h0) mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who wins, what the RAM sees, and who gets data one cycle later
  logic [31:0] shadow [256];
  int          m_owner = 0;
  logic [31:0] m_rdata = '0;
  int          m_run = 0;
  bit          m_boost = 0;
  int          g;
  int          order [3];
  logic [2:0]  e_gnt, e_rv;
  logic [3:0]  e_we;
  logic [31:0] e_addr, e_wdata;
  logic        e_stall;

  function automatic bit wants(int k);
    return (k == 1) ? if_req : (k == 2) ? ls_req : dbg_req;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      m_owner = 0; m_run = 0; m_boost = 0;
      chk("rst_gnt", {29'd0, dbg_gnt, ls_gnt, if_gnt}, 32'd0);
      chk("rst_mem", {27'd0, mem_en, mem_we}, 32'd0);
      chk("rst_addr_wdata", mem_wdata | 32'(mem_addr), 32'd0);
      chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
      chk("rst_rvalid", {29'd0, dbg_rvalid, ls_rvalid, if_rvalid}, 32'd0);
      chk("rst_rdata", if_rdata | ls_rdata | dbg_rdata, 32'd0);
    end else begin
      if (m_boost) order = '{3, 1, 2}; else order = '{3, 2, 1};
      g = 0;
      for (int i = 2; i >= 0; i--) if (wants(order[i])) g = order[i];
      e_gnt = 3'b000; e_we = 4'h0; e_addr = 0; e_wdata = 0;
      if (g == 1) begin e_gnt = 3'b001; e_addr = 32'(if_addr); end
      if (g == 2) begin
        e_gnt = 3'b010; e_addr = 32'(ls_addr); e_wdata = ls_wdata; e_we = ls_we ? ls_be : 4'h0;
      end
      if (g == 3) begin
        e_gnt = 3'b100; e_addr = 32'(dbg_addr); e_wdata = dbg_wdata; e_we = dbg_we ? 4'hF : 4'h0;
      end
      e_stall = (if_req && g != 1) || (ls_req && g != 2);
      e_rv = (m_owner == 0) ? 3'b000 : 3'(1 << (m_owner - 1));
      chk("gnt", {29'd0, dbg_gnt, ls_gnt, if_gnt}, {29'd0, e_gnt});
      chk("mem_en", {31'd0, mem_en}, {31'd0, g != 0});
      chk("mem_we", {28'd0, mem_we}, {28'd0, e_we});
      chk("mem_addr", 32'(mem_addr), e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, e_stall});
      chk("rvalid", {29'd0, dbg_rvalid, ls_rvalid, if_rvalid}, {29'd0, e_rv});
      chk("if_rdata", if_rdata, e_rv[0] ? m_rdata : 32'd0);
      chk("ls_rdata", ls_rdata, e_rv[1] ? m_rdata : 32'd0);
      chk("dbg_rdata", dbg_rdata, e_rv[2] ? m_rdata : 32'd0);
      // advance model to the state after the coming rising edge
      for (int b = 0; b < 4; b++)
        if (e_we[b]) shadow[e_addr[7:0]][8*b +: 8] = e_wdata[8*b +: 8];
      m_owner = (g != 0 && e_we == 4'h0) ? g : 0;
      if (m_owner != 0) m_rdata = shadow[e_addr[7:0]];
      if (if_req && g != 1) begin
        if (m_run < 15) m_run++;
        if (m_run == SMAX) m_boost = 1;
      end else begin
        m_run = 0;
      end
      if (g == 1) m_boost = 0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic idle();
    if_req = 0; ls_req = 0; dbg_req = 0; ls_we = 0; dbg_we = 0; ls_be = 4'h0;
  endtask

  task automatic ls_set(input logic we, input logic [3:0] be, input logic [7:0] a, input logic [31:0] d);
    ls_req = 1; ls_we = we; ls_be = be; ls_addr = a; ls_wdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = 32'h5A000000 | 32'(i);
      shadow[i] = 32'h5A000000 | 32'(i);
    end
    ram[8'h10] = 32'h00500093; shadow[8'h10] = 32'h00500093;
    ram[8'h20] = 32'hCAFE0020; shadow[8'h20] = 32'hCAFE0020;
    ram[8'h30] = 32'h11223344; shadow[8'h30] = 32'h11223344;
    mem_rdata = '0;

    // reset held with every requester asking
    reset = 0;
    if_req = 1; if_addr = 8'h01; ls_set(1'b1, 4'hF, 8'h02, 32'h12345678);
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h03; dbg_wdata = 32'h87654321;
    tick(); tick();
    at_neg();
    chk("lit_rst_gnts", {29'd0, dbg_gnt, ls_gnt, if_gnt}, 32'd0);
    chk("lit_rst_mem_en", {31'd0, mem_en}, 32'd0);

    // first cycle out of reset: IF alone
    tick(); reset = 1; idle(); if_req = 1; if_addr = 8'h10;
    at_neg();
    chk("lit_first_if_gnt", {31'd0, if_gnt}, 32'd1);
    tick(); idle();
    at_neg();
    chk("lit_first_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("lit_first_if_rdata", if_rdata, 32'h00500093);

    // LS beats IF; IF follows next cycle overlapping the LS response
    tick(); if_req = 1; if_addr = 8'h11; ls_set(1'b0, 4'h0, 8'h20, 32'h0);
    at_neg();
    chk("lit_ls_prio_gnt", {30'd0, ls_gnt, if_gnt}, 32'b10);
    chk("lit_ls_prio_stall", {31'd0, cpu_stall}, 32'd1);
    tick(); ls_req = 0;
    at_neg();
    chk("lit_ls_rvalid", {31'd0, ls_rvalid}, 32'd1);
    chk("lit_ls_rdata", ls_rdata, 32'hCAFE0020);
    chk("lit_if_after_ls", {31'd0, if_gnt}, 32'd1);
    tick(); idle();

    // partial store, then read-after-write to the same word
    tick(); ls_set(1'b1, 4'b0011, 8'h30, 32'hAABBCCDD);
    at_neg();
    chk("lit_store_we", {28'd0, mem_we}, 32'h3);
    tick(); ls_set(1'b0, 4'h0, 8'h30, 32'h0);
    tick(); idle();
    at_neg();
    chk("lit_raw_rdata", ls_rdata, 32'h1122CCDD);

    // IF starved by continuous LS reads: boosted on its fifth request cycle
    tick(); if_req = 1; if_addr = 8'h41; ls_set(1'b0, 4'h0, 8'h40, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      at_neg();
      chk($sformatf("lit_starve_c%0d", k), {30'd0, ls_gnt, if_gnt}, (k == 5) ? 32'b01 : 32'b10);
      tick();
    end
    idle();

    // DBG write pre-empts both CPU ports, then DBG reads it back
    tick(); if_req = 1; if_addr = 8'h12; ls_set(1'b0, 4'h0, 8'h21, 32'h0);
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h00; dbg_wdata = 32'hDEADBEEF;
    at_neg();
    chk("lit_dbg_gnt", {29'd0, dbg_gnt, ls_gnt, if_gnt}, 32'b100);
    chk("lit_dbg_we", {28'd0, mem_we}, 32'hF);
    tick(); idle(); dbg_req = 1; dbg_we = 0; dbg_addr = 8'h00;
    at_neg();
    chk("lit_dbg_wr_no_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    tick(); idle();
    at_neg();
    chk("lit_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd1);
    chk("lit_dbg_rdata", dbg_rdata, 32'hDEADBEEF);

    // withdrawn request and three-way contention vectors
    tick(); ls_set(1'b1, 4'hF, 8'h50, 32'h0BADF00D); dbg_req = 1; dbg_we = 0; dbg_addr = 8'h20;
    tick(); idle();
    tick(); if_req = 1; if_addr = 8'h50; ls_set(1'b0, 4'h0, 8'h50, 32'h0); dbg_req = 1; dbg_addr = 8'h10;
    tick(); dbg_req = 0;
    tick(); ls_req = 0;
    tick(); idle();
    at_neg();
    chk("lit_withdrawn_store", ram[8'h50], 32'h5A000050);

    // reset lands the cycle after an IF read grant: response is dropped
    tick(); if_req = 1; if_addr = 8'h10;
    tick(); reset = 0; idle();
    at_neg();
    chk("lit_midread_rvalid", {31'd0, if_rvalid}, 32'd0);
    tick(); reset = 1;
    at_neg();
    chk("lit_post_rst_rvalid", {31'd0, if_rvalid}, 32'd0);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
